phys_reg_free_list: RTL and testbench

Free list of physical register tags in the out-of-order core.

- It receives tags released by the reorder buffer at commit, on `freed_tag_1` and `freed_tag_2`, and supplies fresh tags to the rename stage.
- It is the consuming end of the ROB's freed-tag interface and the producing end of rename's destination-tag allocation.
- It is a circular tag FIFO with two pushes and one pop per cycle.
- A membership bitmap detects illegal double-frees.

---
 rtl/phys_reg_free_list_pkg.sv | 19 +
 rtl/phys_reg_free_list.sv | 84 ++++++++
 tb/tb_phys_reg_free_list.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/phys_reg_free_list_pkg.sv
// Core sizing constants shared by rename, ROB, RS and the physical register free list.
package phys_reg_free_list_pkg;

  localparam int NUM_PHYS = 64;
  localparam int NUM_ARCH = 32;
  localparam int TAG_W    = 6;
  localparam int FL_DEPTH = NUM_PHYS - NUM_ARCH;

  // Tag held in FIFO slot i right after reset.
  function automatic logic [TAG_W-1:0] fl_reset_tag(input int num_arch, input int i);
    return TAG_W'(num_arch + i);
  endfunction

  // Tags above the architectural range start out free.
  function automatic logic fl_reset_member(input int num_arch, input int depth, input int tag);
    return (tag >= num_arch) && (tag < num_arch + depth);
  endfunction

endpackage

// File: rtl/phys_reg_free_list.sv
// Circular free list of physical register tags: two frees from commit, one allocation to rename per cycle.
// A membership bitmap rejects double frees; free_err is sticky until reset.
module phys_reg_free_list #(
  parameter int NUM_PHYS = phys_reg_free_list_pkg::NUM_PHYS,
  parameter int NUM_ARCH = phys_reg_free_list_pkg::NUM_ARCH,
  parameter int DEPTH    = phys_reg_free_list_pkg::FL_DEPTH
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   alloc_req,
  output logic [phys_reg_free_list_pkg::TAG_W-1:0] alloc_tag,
  output logic                                   alloc_valid,
  input  logic [phys_reg_free_list_pkg::TAG_W-1:0] freed_tag_1,
  input  logic [phys_reg_free_list_pkg::TAG_W-1:0] freed_tag_2,
  output logic [$clog2(DEPTH+1)-1:0]             free_count,
  output logic                                   free_err
);
  import phys_reg_free_list_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [TAG_W-1:0]    entries_q [DEPTH];
  logic [PTR_W-1:0]    head_q, head_d, tail_q, tail_d, wr2_idx;
  logic [CNT_W-1:0]    count_q, count_d, room;
  logic [NUM_PHYS-1:0] in_list_q, in_list_d;
  logic                free_err_q, free_err_d;
  logic                pop, push1, push2, bad1, bad2;

  assign alloc_tag   = entries_q[head_q];
  assign alloc_valid = (count_q != '0);
  assign free_count  = count_q;
  assign free_err    = free_err_q;

  always_comb begin
    pop   = alloc_req && (count_q != '0);
    // A same-cycle pop makes space available to the pushes.
    room  = count_q - CNT_W'(pop);
    push1 = 1'b0;
    push2 = 1'b0;
    bad1  = 1'b0;
    bad2  = 1'b0;
    if (freed_tag_1 != '0) begin
      if (in_list_q[freed_tag_1] || (room >= CNT_W'(DEPTH))) bad1 = 1'b1;
      else                                                   push1 = 1'b1;
    end
    if (freed_tag_2 != '0) begin
      if ((freed_tag_2 == freed_tag_1) || in_list_q[freed_tag_2] ||
          ((room + CNT_W'(push1)) >= CNT_W'(DEPTH))) bad2 = 1'b1;
      else                                           push2 = 1'b1;
    end

    in_list_d = in_list_q;
    if (pop)   in_list_d[alloc_tag]   = 1'b0;
    if (push1) in_list_d[freed_tag_1] = 1'b1;
    if (push2) in_list_d[freed_tag_2] = 1'b1;

    head_d     = head_q + PTR_W'(pop);
    wr2_idx    = tail_q + PTR_W'(push1);
    tail_d     = wr2_idx + PTR_W'(push2);
    count_d    = room + CNT_W'(push1) + CNT_W'(push2);
    free_err_d = free_err_q | bad1 | bad2;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= fl_reset_tag(NUM_ARCH, i);
      for (int t = 0; t < NUM_PHYS; t++) in_list_q[t] <= fl_reset_member(NUM_ARCH, DEPTH, t);
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= CNT_W'(DEPTH);
      free_err_q <= 1'b0;
    end else begin
      if (push1) entries_q[tail_q]  <= freed_tag_1;
      if (push2) entries_q[wr2_idx] <= freed_tag_2;
      in_list_q  <= in_list_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      free_err_q <= free_err_d;
    end
  end

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Bench for phys_reg_free_list: directed scenarios then random traffic against a queue-based model.
module tb_phys_reg_free_list;

  localparam int DEPTH = 32;

  logic       clk = 1'b0;
  logic       reset;
  logic       alloc_req;
  logic [5:0] alloc_tag;
  logic       alloc_valid;
  logic [5:0] freed_tag_1;
  logic [5:0] freed_tag_2;
  logic [5:0] free_count;
  logic       free_err;

  phys_reg_free_list dut (
    .clk         (clk),
    .reset       (reset),
    .alloc_req   (alloc_req),
    .alloc_tag   (alloc_tag),
    .alloc_valid (alloc_valid),
    .freed_tag_1 (freed_tag_1),
    .freed_tag_2 (freed_tag_2),
    .free_count  (free_count),
    .free_err    (free_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int q[$];      // free tags in allocation order
  bit err_m;

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    tests++;
    assert (obs === 32'(exp))
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit in_q(input int t);
    foreach (q[i]) if (q[i] == t) return 1'b1;
    return 1'b0;
  endfunction

  // Random tag currently owned by the core (not free, not p0); 0 if none.
  function automatic int pick_owned();
    int pool[$];
    for (int t = 1; t < 64; t++) if (!in_q(t)) pool.push_back(t);
    if (pool.size() == 0) return 0;
    return pool[$urandom_range(0, pool.size() - 1)];
  endfunction

  task automatic check_outputs();
    chk("alloc_valid", 32'(alloc_valid), int'(q.size() != 0));
    chk("free_count", 32'(free_count), q.size());
    chk("free_err", 32'(free_err), int'(err_m));
    if (q.size() != 0) chk("alloc_tag", 32'(alloc_tag), q[0]);
  endtask

  task automatic step(input bit req, input int t1, input int t2);
    bit pop, p1, p2;
    int occ;
    @(negedge clk);
    reset       = 1'b0;
    alloc_req   = req;
    freed_tag_1 = 6'(t1);
    freed_tag_2 = 6'(t2);
    #1;
    check_outputs();
    pop = req && (q.size() > 0);
    occ = q.size() - int'(pop);
    p1  = 1'b0;
    p2  = 1'b0;
    if (t1 != 0) begin
      if (in_q(t1) || occ >= DEPTH) err_m = 1'b1;
      else p1 = 1'b1;
    end
    if (t2 != 0) begin
      if (t2 == t1 || in_q(t2) || occ + int'(p1) >= DEPTH) err_m = 1'b1;
      else p2 = 1'b1;
    end
    if (pop) void'(q.pop_front());
    if (p1) q.push_back(t1);
    if (p2) q.push_back(t2);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset       = 1'b1;
    alloc_req   = 1'b1;
    freed_tag_1 = 6'($urandom_range(1, 63));
    freed_tag_2 = 6'($urandom_range(1, 63));
    q.delete();
    for (int i = 0; i < DEPTH; i++) q.push_back(32 + i);
    err_m = 1'b0;
  endtask

  initial begin
    int t1, t2;
    reset       = 1'b1;
    alloc_req   = 1'b0;
    freed_tag_1 = '0;
    freed_tag_2 = '0;

    // Drain all 32 reset tags, then one request on an empty list.
    do_reset();
    for (int i = 0; i < 33; i++) step(1'b1, 0, 0);
    step(1'b0, 0, 0);

    // Double free from empty: no bypass, order 40 then 7.
    step(1'b1, 40, 7);
    step(1'b1, 0, 0);
    step(1'b1, 0, 0);
    step(1'b0, 0, 0);

    // Full list with simultaneous pop and free.
    do_reset();
    step(1'b1, 5, 0);
    for (int i = 0; i < 32; i++) step(1'b1, 0, 0);
    step(1'b0, 0, 0);

    // Double free of a member, duplicate pair, overflow; sticky error.
    do_reset();
    step(1'b0, 50, 0);
    step(1'b0, 0, 0);
    step(1'b1, 0, 0);
    step(1'b0, 3, 3);
    step(1'b0, 9, 0);
    step(1'b0, 0, 0);

    // Wrap: 31 pops, then frees walking tail across index 31 -> 0.
    do_reset();
    for (int i = 0; i < 31; i++) step(1'b1, 0, 0);
    for (int i = 0; i < 31; i++) step(i % 3 == 0, pick_owned(), 0);
    for (int i = 0; i < 6; i++) begin
      t1 = pick_owned();
      t2 = pick_owned();
      if (t2 == t1) t2 = 0;
      step(1'b1, t1, t2);
    end
    for (int i = 0; i < 34; i++) step(1'b1, 0, 0);

    // Reset in the middle of traffic with frees pending.
    step(1'b0, 12, 13);
    step(1'b1, 14, 0);
    do_reset();
    step(1'b0, 0, 0);

    // Random traffic, mostly legal frees with occasional illegal ones.
    for (int n = 0; n < 3000; n++) begin
      int r;
      if (n % 600 == 599) do_reset();
      r  = $urandom_range(0, 9);
      t1 = (r < 6) ? pick_owned() : (r < 8) ? 0 : $urandom_range(0, 63);
      r  = $urandom_range(0, 9);
      t2 = (r < 6) ? pick_owned() : (r < 8) ? 0 : $urandom_range(0, 63);
      step($urandom_range(0, 3) != 0, t1, t2);
    end
    step(1'b0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
